// File: rtl/sched_pkg.sv
// Shared types and helpers for the eight-way round-robin grant scheduler.
// The rotate-priority search returns {found, index} so callers need no extra OR-reduce.
package sched_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } sched_state_e;

  // Scan from the highest offset down so the request closest to ptr is written last and wins.
  function automatic logic [IDX_W:0] rr_first_one(input logic [N_REQ-1:0] req,
                                                  input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/grant_dec38.sv
// 3-to-8 one-hot decoder with an active-high enable.
// Turns the registered grant index into the one-hot grant vector.
module grant_dec38
  import sched_pkg::*;
(
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_sched8.sv
// Eight-requester round-robin scheduler with a bounded hold timer.
// Grant index, valid and timeout are registered; the one-hot grant is decoded from them.
module rr_grant_sched8
  import sched_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [N_REQ-1:0] gnt,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic [IDX_W-1:0] scan_start;
  logic [IDX_W:0]   pick;
  logic             found;
  logic [IDX_W-1:0] winner;
  logic             rel_drop;
  logic             rel_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      hold_cnt_q  <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  // While granting, the holder drops to lowest priority for any re-arbitration.
  assign scan_start = (state_q == GRANT) ? gnt_idx_q + IDX_W'(1) : ptr_q;
  assign pick       = rr_first_one(req, scan_start);
  assign found      = pick[IDX_W];
  assign winner     = pick[IDX_W-1:0];
  assign rel_drop   = !req[gnt_idx_q];
  assign rel_hold   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_valid_d = 1'b0;
        if (en && found) begin
          state_d     = GRANT;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
          ptr_d       = winner + IDX_W'(1);
        end
      end
      GRANT: begin
        if (!en) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end else if (rel_drop || rel_hold) begin
          timeout_d = rel_hold && !rel_drop;
          if (found) begin
            gnt_idx_d   = winner;
            gnt_valid_d = 1'b1;
            hold_cnt_d  = '0;
            ptr_d       = winner + IDX_W'(1);
          end else begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
          end
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  grant_dec38 u_dec (
    .en_i     (gnt_valid_q),
    .idx_i    (gnt_idx_q),
    .onehot_o (gnt)
  );

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_grant_sched8.sv
// Self-checking bench for rr_grant_sched8: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_grant_sched8;

  localparam int MAX_HOLD = 4;
  localparam int CNT_W    = 5;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       timeout;

  int testCount;
  int failCount;

  // Model state: who owns the grant, how many cycles it has held, where the next search starts.
  bit mBusy;
  int mOwner;
  int mHeld;
  int mPrio;
  bit mTimeout;

  rr_grant_sched8 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int pickWinner(input logic [7:0] r, input int start);
    for (int k = 0; k < 8; k++) begin
      if (r[(start + k) % 8]) return (start + k) % 8;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mBusy    = 1'b0;
    mOwner   = 0;
    mHeld    = 0;
    mPrio    = 0;
    mTimeout = 1'b0;
  endtask

  task automatic modelStep(input bit e, input logic [7:0] r);
    int w;
    bit dropped;
    bit expired;
    mTimeout = 1'b0;
    if (!mBusy) begin
      if (e && r != 8'h00) begin
        w      = pickWinner(r, mPrio);
        mOwner = w;
        mBusy  = 1'b1;
        mHeld  = 1;
        mPrio  = (w + 1) % 8;
      end
    end else begin
      dropped = !r[mOwner];
      expired = (MAX_HOLD != 0) && (mHeld == MAX_HOLD);
      if (!e) begin
        mBusy = 1'b0;
      end else if (dropped || expired) begin
        mTimeout = expired && !dropped;
        if (r != 8'h00) begin
          w      = pickWinner(r, (mOwner + 1) % 8);
          mOwner = w;
          mHeld  = 1;
          mPrio  = (w + 1) % 8;
        end else begin
          mBusy = 1'b0;
        end
      end else begin
        mHeld++;
      end
    end
  endtask

  task automatic checkCycle(input string phase);
    logic [7:0] expGnt;
    expGnt = mBusy ? (8'h01 << mOwner) : 8'h00;
    checkOutput({phase, ".valid"},   {7'h0, gnt_valid}, {7'h0, mBusy});
    checkOutput({phase, ".gnt"},     gnt, expGnt);
    checkOutput({phase, ".timeout"}, {7'h0, timeout}, {7'h0, mTimeout});
    if (mBusy) checkOutput({phase, ".idx"}, {5'h0, gnt_idx}, 8'(mOwner));
  endtask

  task automatic applyStimulus(input string phase, input bit e, input logic [7:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    modelStep(e, r);
    #1;
    checkCycle(phase);
  endtask

  initial begin
    logic [7:0] rq;
    bit         re;
    int         roll;
    testCount = 0;
    failCount = 0;
    modelReset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    #12;
    checkCycle("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b1, 8'h00);

    for (int i = 0; i < 5; i++) applyStimulus("single", 1'b1, 8'h10);
    applyStimulus("single_drop", 1'b1, 8'h00);

    for (int i = 0; i < 3; i++) applyStimulus("b2b", 1'b1, 8'h81);
    applyStimulus("b2b_hand", 1'b1, 8'h80);
    applyStimulus("b2b_hold", 1'b1, 8'h80);
    applyStimulus("b2b_end", 1'b1, 8'h00);

    for (int i = 0; i < 40; i++) applyStimulus("rr", 1'b1, 8'hFF);
    applyStimulus("rr_end", 1'b1, 8'h00);

    for (int i = 0; i < 13; i++) applyStimulus("lone", 1'b1, 8'h04);

    for (int i = 0; i < 2; i++) applyStimulus("dis", 1'b1, 8'h08);
    applyStimulus("dis_off", 1'b0, 8'h08);
    applyStimulus("dis_on", 1'b1, 8'h08);

    // Pull reset between edges while a grant is active; outputs must clear without a clock.
    applyStimulus("pre_rst", 1'b1, 8'h60);
    applyStimulus("pre_rst", 1'b1, 8'h60);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst.gnt",   gnt, 8'h00);
    checkOutput("async_rst.valid", {7'h0, gnt_valid}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("post_rst", 1'b1, 8'hFF);
    checkOutput("post_rst.first_idx", {5'h0, gnt_idx}, 8'h00);

    rq = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      roll = int'($urandom_range(0, 9));
      if (roll >= 6 && roll <= 7) rq = rq ^ (8'h01 << $urandom_range(0, 7));
      else if (roll == 8)         rq = 8'($urandom);
      else if (roll == 9)         rq = 8'h00;
      re = ($urandom_range(0, 15) != 0);
      applyStimulus("rand", re, rq);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/rr_grant_sched8.md
Name: rr_grant_sched8

Overview:
- Eight-requester round-robin arbiter/scheduler for shared resources selected through the team's 3-to-8 decoder select lines.
- Holds a grant while the winner keeps its request asserted, bounded by a hold timer.
- Rotates priority so that every requester is served.
- Produces a registered binary grant index plus a one-hot grant vector derived from it by a decoder stage.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 = unlimited.
- CNT_W, 5, hold-counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scheduler enable; low = no grants issued.
- req  input  8  request vector, bit i = requester i.
- gnt_valid  output  1  a grant is active this cycle.
- gnt_idx  output  3  index of granted requester; meaningful only when gnt_valid=1.
- gnt  output  8  one-hot grant; all zero when gnt_valid=0.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold timer.

Behaviour:
Interface and reset:
- One clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n=0: gnt_valid=0, gnt_idx=0, gnt=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- All outputs are registered; gnt is decoded combinationally from the registered gnt_idx/gnt_valid, with no extra latency.

Winner selection:
- Winner = first set bit of req, scanning ptr, ptr+1, …, wrapping mod 8.

State IDLE:
- If en=1 and req!=0: next cycle state=GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0, ptr=winner+1 (mod 8).
- Latency from request to grant is 1 cycle.

State GRANT, release conditions (evaluated every cycle):
- (a) req[gnt_idx]=0;
- (b) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1;
- (c) en=0.
- No release: hold_cnt increments and the grant is unchanged.

Release by (a) or (b) with en=1:
- Re-arbitrate in the same cycle, using ptr = gnt_idx+1, so the current holder has lowest priority.
- If any req is set, the next cycle carries the new grant back-to-back, with no idle gap.
- The current holder can be re-granted only if no other request is set; hold_cnt restarts at 0.
- If req=0: state=IDLE and gnt_valid=0 next cycle.

Release by (c):
- Next cycle state=IDLE, gnt_valid=0, regardless of req; ptr is kept.

timeout:
- Pulses 1 in the cycle after release by (b) when (a) was not also true.
- If (a) and (b) coincide, the release counts as (a) and there is no timeout pulse.

Other rules:
- Requests changing on non-granted bits never disturb an active grant.
- ptr wraps 7 -> 0.
- hold_cnt saturates at its maximum when MAX_HOLD=0 (no wrap, no release).
- Asynchronous reset mid-grant drops gnt/gnt_valid immediately, without waiting for a clock edge.
- X on req bits is not required to be handled.

Decomposition:
- Shared package sched_pkg holds:
  - state typedef {IDLE, GRANT};
  - N_REQ=8 and IDX_W=3 constants;
  - a rotate-priority first-one function.
- One sub-module, grant_dec38: 3-to-8 one-hot decoder with an active-high enable (gnt_valid) producing gnt from gnt_idx.
- Everything else lives in the top level.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0, en=1 -> gnt_valid=0, gnt=8'h00 for 10 cycles.
- Single requester: req=8'h10 at cycle 0 -> cycle 1 gnt_idx=4, gnt=8'h10; req drops at cycle 5 -> cycle 6 gnt_valid=0.
- Round robin: req=8'hFF held, MAX_HOLD=2 -> grants 0,1,2,…,7,0, each for 2 cycles, with a timeout pulse at each handoff.
- Back-to-back handoff: req=8'h81, holder 0 drops at cycle 3 -> cycle 4 gnt=8'h80, no gap cycle.
- Lone holder at timeout: req=8'h04 only, MAX_HOLD=4 -> regrant of 2 every 4 cycles, timeout pulses, gnt_valid stays 1.
- Disable and async reset: en=0 mid-grant -> next cycle gnt=0; separately, assert rst_n=0 between clock edges -> gnt=0 immediately, and after release the first grant scans from ptr=0.
